// File: rtl/squash_pkg.sv
// Shared encodings for the squash game-flow controller.
package squash_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_OVER   = 3'd4
  } state_e;
endpackage

// File: rtl/squash_btn_sync.sv
// Raw active-low button -> 2-flop synchronizer -> registered falling-edge press pulse.
module squash_btn_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n_i,
  output logic press_o
);
  logic s1_q, s2_q, s3_q, press_q;

  // s3_q is the previous synchronized level; press_q registers the edge so
  // the press reaches the FSM three edges after the button is first sampled low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
      press_q <= 1'b0;
    end else begin
      s1_q    <= btn_n_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      press_q <= s3_q & ~s2_q;
    end
  end

  assign press_o = press_q;
endmodule

// File: rtl/squash_sequencer.sv
// Squash game-flow FSM: attract/serve/play/pause/over, score and lives tracking.
// Define SQUASH_SCORE_BCD_EN for a two-digit packed BCD score (else binary).
module squash_sequencer
  import squash_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_n,
  input  logic       pause_btn_n,
  input  logic       frame_tick,
  input  logic       hit_in,
  input  logic       miss_in,
  output logic       core_new_game_n,
  output logic       core_pause_n,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic       game_over
);
  localparam logic [8:0] SF9     = 9'(SERVE_FRAMES);
  localparam logic [1:0] LIVES_2 = 2'(LIVES);

  logic start_press, pause_press;
  logic hit_q, hit_d_q, miss_q, miss_d_q, tick_q;
  logic hit_edge, miss_edge;
  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d, score_q, score_d, score_inc;
  logic [1:0] lives_q, lives_d;
  logic newg_q, newg_d, pause_n_q, pause_n_d, over_q, over_d;
  logic new_game, serve_entry;

  squash_btn_sync u_start (.clk(clk), .reset_n(reset_n), .btn_n_i(start_n),     .press_o(start_press));
  squash_btn_sync u_pause (.clk(clk), .reset_n(reset_n), .btn_n_i(pause_btn_n), .press_o(pause_press));

  // Core signals are already in clk domain: one capture flop plus delayed copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q <= 1'b0; hit_d_q <= 1'b0;
      miss_q <= 1'b0; miss_d_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      hit_q <= hit_in;   hit_d_q <= hit_q;
      miss_q <= miss_in; miss_d_q <= miss_q;
      tick_q <= frame_tick;
    end
  end

  assign hit_edge  = hit_q & ~hit_d_q;
  assign miss_edge = miss_q & ~miss_d_q;

  always_comb begin
`ifdef SQUASH_SCORE_BCD_EN
    if (score_q == 8'h99)          score_inc = score_q;
    else if (score_q[3:0] == 4'd9) score_inc = {score_q[7:4] + 4'd1, 4'd0};
    else                           score_inc = {score_q[7:4], score_q[3:0] + 4'd1};
`else
    score_inc = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_d     = score_q;
    lives_d     = lives_q;
    new_game    = 1'b0;
    serve_entry = 1'b0;
    case (state_q)
      ST_IDLE:  if (start_press) new_game = 1'b1;
      ST_SERVE: if (tick_q) begin
        cnt_d = cnt_q + 8'd1;
        if ({1'b0, cnt_q} + 9'd1 == SF9) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // A miss outranks both a simultaneous hit and a simultaneous pause.
        if (miss_edge) begin
          lives_d = lives_q - 2'd1;
          if (lives_q == 2'd1) state_d = ST_OVER;
          else                 serve_entry = 1'b1;
        end else begin
          if (hit_edge)    score_d = score_inc;
          if (pause_press) state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: if (pause_press) state_d = ST_PLAY;
      ST_OVER:   if (start_press) new_game = 1'b1;
      default:   state_d = ST_IDLE;
    endcase
    if (new_game) begin
      score_d     = '0;
      lives_d     = LIVES_2;
      serve_entry = 1'b1;
    end
    if (serve_entry) state_d = ST_SERVE;
    cnt_d     = serve_entry ? 8'd0 : cnt_d;
    newg_d    = ~serve_entry;
    pause_n_d = (state_d == ST_IDLE) || (state_d == ST_PLAY);
    over_d    = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      score_q   <= '0;
      lives_q   <= '0;
      newg_q    <= 1'b1;
      pause_n_q <= 1'b1;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      newg_q    <= newg_d;
      pause_n_q <= pause_n_d;
      over_q    <= over_d;
    end
  end

  assign core_new_game_n = newg_q;
  assign core_pause_n    = pause_n_q;
  assign score           = score_q;
  assign lives           = lives_q;
  assign state           = state_q;
  assign game_over       = over_q;
endmodule
